// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Upstream fetch stage. Owns the program counter, drives the
//               RAM_i read port, captures the returned word into a stable
//               instruction register and hands it to decode over a
//               valid/ready handshake. Supports branch redirect, halting at
//               the end of the program and an accepted-instruction counter.
// Ports       :
//   Clk, Reset           clock, asynchronous active-high reset
//   Start                begin fetching from address 0 (IDLE/HALT only)
//   Enable_i, RW_ram_i   RAM_i enable (FETCH only) and read select (always 1)
//   Address_in_i         RAM_i address, equal to the internal PC
//   Out_i                RAM_i read data, valid the cycle after FETCH
//   instruction, pc      captured word and the address it came from
//   instr_valid          instruction holds a fetched word
//   instr_ready          decode accepts the instruction this cycle
//   Branch_en/addr       redirect, honoured only together with an accept
//   halted               fetch stopped at the end of the program
//   instr_count          accepted-instruction count, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int ADDR_W   = 16,
  parameter int INSTR_W  = 32,
  parameter int PROG_LEN = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  output logic               Enable_i,
  output logic               RW_ram_i,
  output logic [ADDR_W-1:0]  Address_in_i,
  input  logic [INSTR_W-1:0] Out_i,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               Branch_en,
  input  logic [ADDR_W-1:0]  Branch_addr,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic [15:0]        instr_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_VALID = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  // One extra bit so the end-of-program compare sees PC+1 before it wraps.
  localparam logic [ADDR_W:0] c_prog_len = (ADDR_W+1)'(PROG_LEN);

  state_t               r_state;
  state_t               w_state_next;
  logic [ADDR_W-1:0]    r_pc;
  logic [INSTR_W-1:0]   r_instruction;
  logic [ADDR_W-1:0]    r_pc_out;
  logic                 r_instr_valid;
  logic                 r_halted;
  logic [15:0]          r_instr_count;

  logic                 w_accept;
  logic [ADDR_W:0]      w_npc_ext;
  logic                 w_npc_halt;

  assign w_accept   = (r_state == S_VALID) && instr_ready;
  assign w_npc_ext  = Branch_en ? {1'b0, Branch_addr} : ({1'b0, r_pc} + 1'b1);
  assign w_npc_halt = (w_npc_ext >= c_prog_len);

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and RAM enable
  always_comb begin
    w_state_next = r_state;
    Enable_i     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) w_state_next = S_FETCH;
      end
      S_FETCH: begin
        Enable_i     = 1'b1;
        w_state_next = S_LATCH;
      end
      S_LATCH: begin
        w_state_next = S_VALID;
      end
      S_VALID: begin
        if (instr_ready) w_state_next = w_npc_halt ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        if (Start) w_state_next = S_FETCH;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: PC, instruction register, handshake flag, halt flag, counter
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pc          <= '0;
      r_instruction <= '0;
      r_pc_out      <= '0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_instr_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) r_pc <= '0;
        end
        S_LATCH: begin
          // RAM data for the address presented in FETCH is on Out_i now.
          r_instruction <= Out_i;
          r_pc_out      <= r_pc;
          r_instr_valid <= 1'b1;
        end
        S_VALID: begin
          if (w_accept) begin
            r_instr_valid <= 1'b0;
            if (r_instr_count != 16'hFFFF) r_instr_count <= r_instr_count + 16'd1;
            r_pc <= w_npc_ext[ADDR_W-1:0];
            if (w_npc_halt) r_halted <= 1'b1;
          end
        end
        S_HALT: begin
          if (Start) begin
            r_halted      <= 1'b0;
            r_pc          <= '0;
            r_instr_count <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign RW_ram_i     = 1'b1;
  assign Address_in_i = r_pc;
  assign instruction  = r_instruction;
  assign instr_valid  = r_instr_valid;
  assign pc           = r_pc_out;
  assign halted       = r_halted;
  assign instr_count  = r_instr_count;

endmodule
`default_nettype wire
